// File: rtl/lut_config_loader.sv
// lut_config_loader: bit-serial to parallel config word loader for a column of fracturable LUTs.
// Optional per-word even parity with a sticky parity_err output: define LUT_CFG_PARITY_EN.
module lut_config_loader #(
   parameter int INPUTS   = 4,
   parameter int MEM_SIZE = 2**INPUTS,
   parameter int WORD_W   = 2*MEM_SIZE+1,
   parameter int NUM_LUTS = 4,
   parameter int IDX_W    = ($clog2(NUM_LUTS) > 1) ? $clog2(NUM_LUTS) : 1
) (
   input  logic                cclk,
   input  logic                rst,
   input  logic                cfg_start,
   input  logic                cfg_bit,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   output logic [WORD_W-1:0]   config_out,
   output logic [NUM_LUTS-1:0] cen,
   output logic [IDX_W-1:0]    lut_idx,
   output logic                busy,
   output logic                done
`ifdef LUT_CFG_PARITY_EN
   ,
   output logic                parity_err
`endif
);

`ifdef LUT_CFG_PARITY_EN
   localparam int BITS = WORD_W + 1;
`else
   localparam int BITS = WORD_W;
`endif
   localparam int CNT_W = $clog2(BITS + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DONE} state_t;

   state_t            state;
   logic [WORD_W-1:0] shreg;
   logic [CNT_W-1:0]  bit_cnt;
   logic              xfer;
   logic              last_bit;
   logic [WORD_W-1:0] word_nxt;
   logic [WORD_W-1:0] commit_word;
   logic              commit_ok;
   logic              shift_data;

   assign xfer     = cfg_valid & cfg_ready;
   assign last_bit = (bit_cnt == CNT_W'(BITS - 1));
   assign word_nxt = {shreg[WORD_W-2:0], cfg_bit};

`ifdef LUT_CFG_PARITY_EN
   logic par_acc;

   // The trailing parity bit is never shifted into the data word.
   assign commit_word = shreg;
   assign commit_ok   = ~(par_acc ^ cfg_bit);
   assign shift_data  = ~last_bit;

   always_ff @(posedge cclk) begin
      if (rst) begin
         par_acc    <= 1'b0;
         parity_err <= 1'b0;
      end else if ((state == IDLE || state == DONE) && cfg_start) begin
         par_acc    <= 1'b0;
         parity_err <= 1'b0;
      end else if (state == SHIFT && xfer) begin
         par_acc <= last_bit ? 1'b0 : (par_acc ^ cfg_bit);
         if (last_bit && !commit_ok)
            parity_err <= 1'b1;
      end
   end
`else
   assign commit_word = word_nxt;
   assign commit_ok   = 1'b1;
   assign shift_data  = 1'b1;
`endif

   always_ff @(posedge cclk) begin
      if (rst) begin
         state      <= IDLE;
         config_out <= '0;
         cen        <= '0;
         lut_idx    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         cfg_ready  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         cen <= '0;
         case (state)
            IDLE, DONE: begin
               if (cfg_start) begin
                  state     <= SHIFT;
                  lut_idx   <= '0;
                  bit_cnt   <= '0;
                  shreg     <= '0;
                  cfg_ready <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end
            end
            SHIFT: begin
               if (xfer) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (shift_data)
                     shreg <= word_nxt;
                  // config_out loads on the COMMIT entry edge so it is stable under the cen strobe.
                  if (last_bit) begin
                     state     <= COMMIT;
                     cfg_ready <= 1'b0;
                     if (commit_ok) begin
                        config_out <= commit_word;
                        cen        <= NUM_LUTS'(1) << lut_idx;
                     end
                  end
               end
            end
            COMMIT: begin
               bit_cnt <= '0;
               if (lut_idx == IDX_W'(NUM_LUTS - 1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  lut_idx   <= lut_idx + 1'b1;
                  state     <= SHIFT;
                  cfg_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
